// File: rtl/fire_motion_if.sv
// Fire sprite motion interface: vsync and key levels in, sprite state out.
// The game-logic block takes the slave side; the driver of vsync and the keys
// takes the master side.
interface fire_motion_if;
  logic       vsync;
  logic       key_left;
  logic       key_right;
  logic       key_jump;
  logic [9:0] FireX;
  logic [9:0] FireY;
  logic [1:0] animation_frame;
  logic       left_moving;
  logic       right_moving;
  logic       in_air;

  modport master (
    output vsync, key_left, key_right, key_jump,
    input  FireX, FireY, animation_frame, left_moving, right_moving, in_air
  );

  modport slave (
    input  vsync, key_left, key_right, key_jump,
    output FireX, FireY, animation_frame, left_moving, right_moving, in_air
  );
endinterface

// File: rtl/fire_motion.sv
// fire_motion: per-frame movement of the "fire" sprite.
// Walks left/right with wall clamping and a three-frame walk cycle.
// Optional feature macro FIRE_JUMP_EN: when defined, adds a GROUND/AIR
// vertical FSM with jump and gravity; when undefined, the sprite stays on the
// floor, in_air is 0 and key_jump is ignored.
// Game state advances once per frame, on the synchronized falling edge of vsync.
module fire_motion #(
  parameter int X_START  = 320,
  parameter int FLOOR_Y  = 467,
  parameter int X_MIN    = 13,
  parameter int X_MAX    = 626,
  parameter int STEP_X   = 2,
  parameter int JUMP_V   = 8,
  parameter int MAX_FALL = 8,
  parameter int ANIM_DIV = 4
) (
  input logic          vga_clk,
  input logic          reset_n,
  fire_motion_if.slave bus
);

  localparam logic [9:0]         L_X_START  = 10'(X_START);
  localparam logic [9:0]         L_FLOOR    = 10'(FLOOR_Y);
  localparam logic [9:0]         L_X_MIN_U  = 10'(X_MIN);
  localparam logic [9:0]         L_X_MAX_U  = 10'(X_MAX);
  localparam logic signed [10:0] L_X_MIN    = 11'(X_MIN);
  localparam logic signed [10:0] L_X_MAX    = 11'(X_MAX);
  localparam logic signed [10:0] L_STEP     = 11'(STEP_X);
  localparam logic [1:0]         L_DIV_LAST = 2'(ANIM_DIV - 1);

  // vsync synchronizer and edge-detect history, all idle-high
  logic r_vsyncMeta;
  logic r_vsyncSync;
  logic r_vsyncPrev;

  // horizontal and animation state
  logic [9:0] r_fireX;
  logic       r_left;
  logic       r_right;
  logic [1:0] r_animFrame;
  logic [1:0] r_animDiv;

  logic                w_frameTick;
  logic                w_goLeft;
  logic                w_goRight;
  logic                w_onGround;
  logic                w_walking;
  logic signed [10:0]  w_xWide;
  logic signed [10:0]  w_xSum;
  logic [9:0]          w_xNext;

  // Bring vsync into the vga_clk domain and keep one extra stage for edge detection
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vsyncMeta <= 1'b1;
      r_vsyncSync <= 1'b1;
      r_vsyncPrev <= 1'b1;
    end else begin
      r_vsyncMeta <= bus.vsync;
      r_vsyncSync <= r_vsyncMeta;
      r_vsyncPrev <= r_vsyncSync;
    end
  end

  assign w_frameTick = r_vsyncPrev & ~r_vsyncSync;
  assign w_goLeft    = bus.key_left & ~bus.key_right;
  assign w_goRight   = bus.key_right & ~bus.key_left;
  assign w_walking   = (w_goLeft | w_goRight) & w_onGround;

  // Next X computed wide and signed so a step past either wall clamps instead of wrapping
  always_comb begin
    w_xWide = signed'({1'b0, r_fireX});
    w_xSum  = w_xWide;
    if (w_goLeft) begin
      w_xSum = w_xWide - L_STEP;
    end else if (w_goRight) begin
      w_xSum = w_xWide + L_STEP;
    end
    if (w_xSum < L_X_MIN) begin
      w_xNext = L_X_MIN_U;
    end else if (w_xSum > L_X_MAX) begin
      w_xNext = L_X_MAX_U;
    end else begin
      w_xNext = w_xSum[9:0];
    end
  end

  // Horizontal position and facing flags; flags stay set while pinned at a wall
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fireX <= L_X_START;
      r_left  <= 1'b0;
      r_right <= 1'b0;
    end else if (w_frameTick) begin
      r_fireX <= w_xNext;
      r_left  <= w_goLeft;
      r_right <= w_goRight;
    end
  end

  // Walk cycle 0->1->2->0 paced by the divider; cleared when idle on ground, frozen in the air
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_animFrame <= 2'd0;
      r_animDiv   <= 2'd0;
    end else if (w_frameTick) begin
      if (w_walking) begin
        if (r_animDiv == L_DIV_LAST) begin
          r_animDiv   <= 2'd0;
          r_animFrame <= (r_animFrame == 2'd2) ? 2'd0 : r_animFrame + 2'd1;
        end else begin
          r_animDiv <= r_animDiv + 2'd1;
        end
      end else if (w_onGround) begin
        r_animFrame <= 2'd0;
        r_animDiv   <= 2'd0;
      end
    end
  end

`ifdef FIRE_JUMP_EN
  typedef enum logic {
    ST_GROUND = 1'b0,
    ST_AIR    = 1'b1
  } vState_t;

  localparam logic signed [5:0]  L_JUMP_V   = 6'(JUMP_V);
  localparam logic signed [5:0]  L_MAX_FALL = 6'(MAX_FALL);
  localparam logic signed [10:0] L_FLOOR_S  = 11'(FLOOR_Y);
  localparam logic signed [10:0] L_CEIL_S   = 11'sd12;
  localparam logic [9:0]         L_CEIL     = 10'd12;

  vState_t            r_vState;
  logic signed [5:0]  r_vy;
  logic               r_jumpPrev;
  logic [9:0]         r_fireY;
  logic               r_inAir;

  logic signed [10:0] w_ySum;
  logic signed [5:0]  w_vyNext;

  // Candidate Y after applying velocity, and gravity-accelerated velocity capped at the fall limit
  always_comb begin
    w_ySum   = signed'({1'b0, r_fireY}) + signed'({{5{r_vy[5]}}, r_vy});
    w_vyNext = (r_vy >= L_MAX_FALL) ? L_MAX_FALL : r_vy + 6'sd1;
  end

  assign w_onGround = (r_vState == ST_GROUND);

  // Vertical FSM: rising edge of key_jump launches, gravity each frame, floor lands, ceiling stops
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vState   <= ST_GROUND;
      r_vy       <= 6'sd0;
      r_jumpPrev <= 1'b0;
      r_fireY    <= L_FLOOR;
      r_inAir    <= 1'b0;
    end else if (w_frameTick) begin
      r_jumpPrev <= bus.key_jump;
      case (r_vState)
        ST_GROUND: begin
          if (bus.key_jump && !r_jumpPrev) begin
            r_vState <= ST_AIR;
            r_vy     <= -L_JUMP_V;
            r_inAir  <= 1'b1;
          end
        end
        ST_AIR: begin
          if (w_ySum >= L_FLOOR_S) begin
            r_fireY  <= L_FLOOR;
            r_vy     <= 6'sd0;
            r_vState <= ST_GROUND;
            r_inAir  <= 1'b0;
          end else if (w_ySum < L_CEIL_S) begin
            r_fireY <= L_CEIL;
            r_vy    <= 6'sd0;
          end else begin
            r_fireY <= w_ySum[9:0];
            r_vy    <= w_vyNext;
          end
        end
        default: begin
          r_vState <= ST_GROUND;
          r_inAir  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.FireY  = r_fireY;
  assign bus.in_air = r_inAir;
`else
  assign w_onGround = 1'b1;
  assign bus.FireY  = L_FLOOR;
  assign bus.in_air = 1'b0;
`endif

  assign bus.FireX           = r_fireX;
  assign bus.animation_frame = r_animFrame;
  assign bus.left_moving     = r_left;
  assign bus.right_moving    = r_right;

endmodule

// File: tb/tb_fire_motion.sv
// Testbench for fire_motion: table-driven walking vectors plus hand-written
// jump/reset sequences, with a per-frame scoreboard fed by a behavioural model.
// Works with FIRE_JUMP_EN either defined or undefined.
module tb_fire_motion;

`ifdef FIRE_JUMP_EN
  localparam bit JUMP_EN = 1'b1;
`else
  localparam bit JUMP_EN = 1'b0;
`endif

  logic vga_clk = 1'b0;
  logic reset_n = 1'b0;

  fire_motion_if bus ();

  fire_motion dut (
    .vga_clk (vga_clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // 100 MHz-style free-running clock
  always #5 vga_clk = ~vga_clk;

  typedef struct {
    int x;
    int y;
    int frame;
    int left;
    int right;
    int air;
  } expect_t;

  typedef struct {
    bit l;
    bit r;
    int frames;
    int expX;
    int expFrame;
    int expLeft;
    int expRight;
  } vec_t;

  expect_t sbQueue[$];
  vec_t    vecs[8];

  int checks = 0;
  int errors = 0;

  int mX, mY, mVy, mFrame, mDiv, mLeft, mRight, mAir, mJumpPrev;

  task automatic checkValue(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic resetModel();
    mX = 320; mY = 467; mVy = 0; mFrame = 0; mDiv = 0;
    mLeft = 0; mRight = 0; mAir = 0; mJumpPrev = 0;
  endtask

  task automatic stepModel(input bit l, input bit r, input bit j);
    int airBefore;
    int s;
    bit oneKey;
    airBefore = mAir;
    oneKey = l ^ r;
    if (l && !r) begin
      mX = (mX - 2 < 13) ? 13 : mX - 2;
      mLeft = 1; mRight = 0;
    end else if (r && !l) begin
      mX = (mX + 2 > 626) ? 626 : mX + 2;
      mLeft = 0; mRight = 1;
    end else begin
      mLeft = 0; mRight = 0;
    end
    if (oneKey && airBefore == 0) begin
      if (mDiv == 3) begin
        mDiv = 0;
        mFrame = (mFrame + 1) % 3;
      end else begin
        mDiv = mDiv + 1;
      end
    end else if (airBefore == 0) begin
      mDiv = 0; mFrame = 0;
    end
    if (JUMP_EN) begin
      if (airBefore == 0) begin
        if (j && mJumpPrev == 0) begin
          mAir = 1; mVy = -8;
        end
      end else begin
        s = mY + mVy;
        if (s >= 467) begin
          mY = 467; mVy = 0; mAir = 0;
        end else if (s < 12) begin
          mY = 12; mVy = 0;
        end else begin
          mY = s;
          mVy = (mVy + 1 > 8) ? 8 : mVy + 1;
        end
      end
      mJumpPrev = j;
    end
  endtask

  // One frame: keys held, vsync low then high; the model's prediction is queued
  task automatic applyStimulus(input bit l, input bit r, input bit j);
    expect_t e;
    @(negedge vga_clk);
    bus.key_left  = l;
    bus.key_right = r;
    bus.key_jump  = j;
    stepModel(l, r, j);
    e.x = mX; e.y = mY; e.frame = mFrame; e.left = mLeft; e.right = mRight; e.air = mAir;
    sbQueue.push_back(e);
    bus.vsync = 1'b0;
    repeat (4) @(posedge vga_clk);
    bus.vsync = 1'b1;
    repeat (4) @(posedge vga_clk);
    @(negedge vga_clk);
  endtask

  task automatic checkOutput();
    expect_t e;
    if (sbQueue.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard: got empty queue, expected a pending frame");
    end else begin
      e = sbQueue.pop_front();
      checkValue("sb FireX", int'(bus.FireX), e.x);
      checkValue("sb FireY", int'(bus.FireY), e.y);
      checkValue("sb animation_frame", int'(bus.animation_frame), e.frame);
      checkValue("sb left_moving", int'(bus.left_moving), e.left);
      checkValue("sb right_moving", int'(bus.right_moving), e.right);
      checkValue("sb in_air", int'(bus.in_air), e.air);
    end
  endtask

  task automatic frame(input bit l, input bit r, input bit j);
    applyStimulus(l, r, j);
    checkOutput();
  endtask

  task automatic doReset();
    @(negedge vga_clk);
    reset_n = 1'b0;
    bus.vsync = 1'b1;
    bus.key_left = 1'b0;
    bus.key_right = 1'b0;
    bus.key_jump = 1'b0;
    repeat (3) @(posedge vga_clk);
    @(negedge vga_clk);
    reset_n = 1'b1;
    resetModel();
    sbQueue.delete();
    repeat (2) @(negedge vga_clk);
  endtask

  initial begin
    int airCount;
    int minY;
    int takeoffs;
    int prevAir;

    vecs[0] = '{l: 1'b0, r: 1'b0, frames: 10,  expX: 320, expFrame: 0, expLeft: 0, expRight: 0};
    vecs[1] = '{l: 1'b0, r: 1'b1, frames: 3,   expX: 326, expFrame: 0, expLeft: 0, expRight: 1};
    vecs[2] = '{l: 1'b0, r: 1'b1, frames: 1,   expX: 328, expFrame: 1, expLeft: 0, expRight: 1};
    vecs[3] = '{l: 1'b1, r: 1'b1, frames: 5,   expX: 328, expFrame: 0, expLeft: 0, expRight: 0};
    vecs[4] = '{l: 1'b1, r: 1'b0, frames: 4,   expX: 320, expFrame: 1, expLeft: 1, expRight: 0};
    vecs[5] = '{l: 1'b0, r: 1'b0, frames: 1,   expX: 320, expFrame: 0, expLeft: 0, expRight: 0};
    vecs[6] = '{l: 1'b0, r: 1'b1, frames: 160, expX: 626, expFrame: 1, expLeft: 0, expRight: 1};
    vecs[7] = '{l: 1'b1, r: 1'b0, frames: 2,   expX: 622, expFrame: 1, expLeft: 1, expRight: 0};

    bus.vsync = 1'b1;
    bus.key_left = 1'b0;
    bus.key_right = 1'b0;
    bus.key_jump = 1'b0;

    $display("[TB] reset state");
    doReset();
    checkValue("reset FireX", int'(bus.FireX), 320);
    checkValue("reset FireY", int'(bus.FireY), 467);
    checkValue("reset animation_frame", int'(bus.animation_frame), 0);
    checkValue("reset left_moving", int'(bus.left_moving), 0);
    checkValue("reset right_moving", int'(bus.right_moving), 0);
    checkValue("reset in_air", int'(bus.in_air), 0);

    $display("[TB] walking vector table");
    for (int v = 0; v < 8; v++) begin
      for (int f = 0; f < vecs[v].frames; f++) begin
        frame(vecs[v].l, vecs[v].r, 1'b0);
      end
      checkValue($sformatf("vec%0d FireX", v), int'(bus.FireX), vecs[v].expX);
      checkValue($sformatf("vec%0d animation_frame", v), int'(bus.animation_frame), vecs[v].expFrame);
      checkValue($sformatf("vec%0d left_moving", v), int'(bus.left_moving), vecs[v].expLeft);
      checkValue($sformatf("vec%0d right_moving", v), int'(bus.right_moving), vecs[v].expRight);
      checkValue($sformatf("vec%0d FireY", v), int'(bus.FireY), 467);
    end

    $display("[TB] left wall, 200 frames");
    doReset();
    for (int f = 0; f < 200; f++) begin
      frame(1'b1, 1'b0, 1'b0);
    end
    checkValue("leftwall FireX", int'(bus.FireX), 13);
    checkValue("leftwall left_moving", int'(bus.left_moving), 1);
    checkValue("leftwall animation_frame", int'(bus.animation_frame), 2);

    if (JUMP_EN) begin
      $display("[TB] single jump from rest");
      doReset();
      frame(1'b0, 1'b0, 1'b1);
      checkValue("takeoff in_air", int'(bus.in_air), 1);
      checkValue("takeoff FireY", int'(bus.FireY), 467);
      airCount = 1;
      minY = 467;
      for (int f = 0; f < 30; f++) begin
        frame(1'b0, 1'b0, 1'b0);
        if (bus.in_air) airCount++;
        if (int'(bus.FireY) < minY) minY = int'(bus.FireY);
      end
      checkValue("jump airtime", airCount, 17);
      checkValue("jump apex FireY", minY, 431);
      checkValue("landing FireY", int'(bus.FireY), 467);
      checkValue("landing in_air", int'(bus.in_air), 0);

      $display("[TB] jump held 40 frames while walking right");
      doReset();
      takeoffs = 0;
      prevAir = 0;
      for (int f = 0; f < 40; f++) begin
        frame(1'b0, 1'b1, 1'b1);
        if (bus.in_air && prevAir == 0) takeoffs++;
        prevAir = int'(bus.in_air);
      end
      checkValue("held jump takeoffs", takeoffs, 1);
      checkValue("held jump in_air", int'(bus.in_air), 0);
      checkValue("held jump FireX", int'(bus.FireX), 400);

      $display("[TB] reset at jump apex");
      doReset();
      frame(1'b0, 1'b0, 1'b1);
      for (int f = 0; f < 8; f++) begin
        frame(1'b0, 1'b0, 1'b0);
      end
      checkValue("apex FireY", int'(bus.FireY), 431);
      reset_n = 1'b0;
      #1;
      checkValue("async reset FireY", int'(bus.FireY), 467);
      checkValue("async reset in_air", int'(bus.in_air), 0);
      repeat (2) @(posedge vga_clk);
      @(negedge vga_clk);
      reset_n = 1'b1;
      resetModel();
      sbQueue.delete();
      frame(1'b0, 1'b0, 1'b0);
      checkValue("post-reset FireY", int'(bus.FireY), 467);
      frame(1'b0, 1'b0, 1'b1);
      checkValue("post-reset takeoff in_air", int'(bus.in_air), 1);
      frame(1'b0, 1'b0, 1'b0);
      checkValue("post-reset first rise FireY", int'(bus.FireY), 459);
    end else begin
      $display("[TB] jump key ignored without jump feature");
      doReset();
      frame(1'b0, 1'b0, 1'b1);
      for (int f = 0; f < 5; f++) begin
        frame(1'b0, 1'b0, 1'b0);
      end
      checkValue("nojump FireY", int'(bus.FireY), 467);
      checkValue("nojump in_air", int'(bus.in_air), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
